// File: rtl/eth_rx_frame_filter_if.sv
// AXI4-Stream beat bundle used on both sides of the Ethernet RX frame filter.
// The master drives the payload and the slave returns tready.
interface eth_rx_frame_filter_if;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tvalid;
   logic        tlast;
   logic        tuser;
   logic        tready;

   modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_rx_frame_filter.sv
// Store-and-forward RX filter: buffers each MAC frame and releases only complete, good,
// addressed frames downstream. Rejected frames are rewound out of the buffer and counted.
module eth_rx_frame_filter #(
   parameter int unsigned DEPTH_LOG2   = 9,
   parameter int unsigned MAX_WORDS    = 190,
   parameter logic [47:0] LOCAL_MAC    = 48'h02_00_00_00_00_01,
   parameter bit          ACCEPT_MCAST = 1'b0
) (
   input  logic                  user_clk,
   input  logic                  cold_reset_n,
   eth_rx_frame_filter_if.slave  s_axis,
   eth_rx_frame_filter_if.master m_axis,
   output logic [15:0]           drop_err_cnt,
   output logic [15:0]           drop_addr_cnt,
   output logic [15:0]           drop_ovf_cnt,
   output logic [31:0]           good_cnt
);

   function automatic logic [47:0] bswap48(input logic [47:0] v);
      logic [47:0] r;
      for (int i = 0; i < 6; i++) r[8*i +: 8] = v[8*(5-i) +: 8];
      return r;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   localparam int unsigned   PW       = DEPTH_LOG2 + 1;
   localparam int unsigned   DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH - 1);
   localparam logic [47:0]   MAC_WIRE = bswap48(LOCAL_MAC);
   localparam logic [15:0]   MAX_W    = 16'(MAX_WORDS);

   typedef enum logic [1:0] {S_SYNC, S_IDLE, S_ACCEPT, S_DISCARD} state_t;

   state_t          r_state;
   logic [PW-1:0]   r_wr_ptr, r_commit_ptr, r_rd_ptr;
   logic [15:0]     r_wcnt;
   logic [15:0]     r_drop_err, r_drop_addr, r_drop_ovf;
   logic [31:0]     r_good;
   logic [72:0]     r_mem [DEPTH];

   logic            r_vld_p1, r_vld_p2;
   logic [72:0]     r_word_p1;
   logic [63:0]     r_data_p2;
   logic [7:0]      r_keep_p2;
   logic            r_last_p2;

   logic [PW-1:0]   w_used;
   logic            w_full, w_match, w_len_ovf, w_we, w_adv_p1, w_rd_en;

   // Full compares against the registered read pointer, so it may lag a read by one cycle.
   assign w_used    = r_wr_ptr - r_rd_ptr;
   assign w_full    = (w_used == FULL_LVL);
   assign w_match   = (s_axis.tdata[47:0] == MAC_WIRE) || (&s_axis.tdata[47:0]) ||
                      (ACCEPT_MCAST && s_axis.tdata[0]);
   assign w_len_ovf = (r_wcnt >= MAX_W);
   assign w_we      = s_axis.tvalid && !w_full &&
                      (((r_state == S_IDLE) && w_match) || ((r_state == S_ACCEPT) && !w_len_ovf));

   assign s_axis.tready = 1'b1;

   always_ff @(posedge user_clk) begin
      if (w_we) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
   end

   always_ff @(posedge user_clk or negedge cold_reset_n) begin
      if (!cold_reset_n) begin
         r_state      <= S_SYNC;
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_wcnt       <= '0;
         r_drop_err   <= '0;
         r_drop_addr  <= '0;
         r_drop_ovf   <= '0;
         r_good       <= '0;
      end else if (s_axis.tvalid) begin
         case (r_state)
            S_SYNC: if (s_axis.tlast) r_state <= S_IDLE;
            S_IDLE: begin
               if (!w_match) begin
                  r_drop_addr <= sat_inc16(r_drop_addr);
                  r_state     <= s_axis.tlast ? S_IDLE : S_DISCARD;
               end else if (w_full) begin
                  r_drop_ovf <= sat_inc16(r_drop_ovf);
                  r_state    <= s_axis.tlast ? S_IDLE : S_DISCARD;
               end else if (s_axis.tlast) begin
                  if (s_axis.tuser) begin
                     r_drop_err <= sat_inc16(r_drop_err);
                  end else begin
                     r_wr_ptr     <= r_wr_ptr + 1'b1;
                     r_commit_ptr <= r_wr_ptr + 1'b1;
                     r_good       <= sat_inc32(r_good);
                  end
               end else begin
                  r_wr_ptr <= r_wr_ptr + 1'b1;
                  r_wcnt   <= 16'd1;
                  r_state  <= S_ACCEPT;
               end
            end
            S_ACCEPT: begin
               if (w_full || w_len_ovf) begin
                  r_wr_ptr   <= r_commit_ptr;
                  r_drop_ovf <= sat_inc16(r_drop_ovf);
                  r_state    <= s_axis.tlast ? S_IDLE : S_DISCARD;
               end else if (s_axis.tlast) begin
                  if (s_axis.tuser) begin
                     r_wr_ptr   <= r_commit_ptr;
                     r_drop_err <= sat_inc16(r_drop_err);
                  end else begin
                     r_wr_ptr     <= r_wr_ptr + 1'b1;
                     r_commit_ptr <= r_wr_ptr + 1'b1;
                     r_good       <= sat_inc32(r_good);
                  end
                  r_state <= S_IDLE;
               end else begin
                  r_wr_ptr <= r_wr_ptr + 1'b1;
                  r_wcnt   <= r_wcnt + 16'd1;
               end
            end
            S_DISCARD: if (s_axis.tlast) r_state <= S_IDLE;
            default:   r_state <= S_SYNC;
         endcase
      end
   end

   // p1: BRAM read register; p2: output register that holds while stalled.
   assign w_adv_p1 = !r_vld_p2 || m_axis.tready;
   assign w_rd_en  = (r_rd_ptr != r_commit_ptr) && (!r_vld_p1 || w_adv_p1);

   always_ff @(posedge user_clk) begin
      if (w_rd_en) r_word_p1 <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
   end

   always_ff @(posedge user_clk or negedge cold_reset_n) begin
      if (!cold_reset_n) begin
         r_rd_ptr  <= '0;
         r_vld_p1  <= 1'b0;
         r_vld_p2  <= 1'b0;
         r_data_p2 <= '0;
         r_keep_p2 <= '0;
         r_last_p2 <= 1'b0;
      end else begin
         if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_vld_p1 <= 1'b1;
         end else if (w_adv_p1) begin
            r_vld_p1 <= 1'b0;
         end
         if (w_adv_p1) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) {r_last_p2, r_keep_p2, r_data_p2} <= r_word_p1;
         end
      end
   end

   assign m_axis.tdata  = r_data_p2;
   assign m_axis.tkeep  = r_keep_p2;
   assign m_axis.tlast  = r_last_p2;
   assign m_axis.tvalid = r_vld_p2;
   assign m_axis.tuser  = 1'b0;

   assign drop_err_cnt  = r_drop_err;
   assign drop_addr_cnt = r_drop_addr;
   assign drop_ovf_cnt  = r_drop_ovf;
   assign good_cnt      = r_good;

endmodule
